// File: rtl/digit_recog_pkg.sv
// Shared types for the digit recognition output stage: activation array,
// decider FSM state and widths.
package digit_recog_pkg;
  localparam int DATA_W     = 4;
  localparam int NUM_DIGITS = 10;
  localparam int DIGIT_W    = 4;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  // Element 0 sits in the most significant nibble, matching the sigmoid bank.
  typedef logic [0:NUM_DIGITS-1][DATA_W-1:0] act_arr_t;
endpackage

// File: rtl/digit_decider_if.sv
// Handshake and result bus between the top-level controller and digit_decider.
interface digit_decider_if;
  import digit_recog_pkg::*;

  logic               start;
  logic               clear;
  act_arr_t           digit_weights;
  logic               busy;
  logic               done;
  logic [DIGIT_W-1:0] digit;
  logic [DATA_W-1:0]  confidence;
  logic               valid;

  modport master (output start, clear, digit_weights,
                  input  busy, done, digit, confidence, valid);
  modport slave  (input  start, clear, digit_weights,
                  output busy, done, digit, confidence, valid);
endinterface

// File: rtl/digit_decider_idx_counter.sv
// Scan index counter 0..NUM_DIGITS-1 with enable, clear and a last flag.
module digit_decider_idx_counter
  import digit_recog_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic               clr,
  input  logic               en,
  output logic [DIGIT_W-1:0] idx,
  output logic               last
);
  assign last = (idx == DIGIT_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)   idx <= '0;
    else if (clr) idx <= '0;
    else if (en)  idx <= last ? '0 : idx + 1'b1;
  end
endmodule

// File: rtl/digit_decider.sv
// Sequential argmax over the 10 output activations with a start/busy/done
// handshake; publishes digit, confidence and a threshold-qualified valid.
module digit_decider
  import digit_recog_pkg::*;
#(
  parameter int THRESHOLD = 8
) (
  input  logic            clk,
  input  logic            n_rst,
  digit_decider_if.slave  bus
);
  localparam logic [DATA_W-1:0] THR = DATA_W'(THRESHOLD);

  state_e             state;
  act_arr_t           snap;
  logic [DATA_W-1:0]  best_val;
  logic [DIGIT_W-1:0] best_idx;
  logic [DIGIT_W-1:0] idx;
  logic               last;

  logic               busy_r, done_r, valid_r;
  logic [DIGIT_W-1:0] digit_r;
  logic [DATA_W-1:0]  conf_r;

  logic [DATA_W-1:0]  cur_val, nxt_val;
  logic [DIGIT_W-1:0] nxt_idx;
  logic               take;

  digit_decider_idx_counter u_idx (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (bus.clear || state != SCAN),
    .en    (state == SCAN),
    .idx   (idx),
    .last  (last)
  );

  // Strict compare keeps the lowest index on ties; idx 0 seeds the best.
  always_comb begin
    cur_val = snap[idx];
    take    = (idx == '0) || (cur_val > best_val);
    nxt_val = take ? cur_val : best_val;
    nxt_idx = take ? idx : best_idx;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      snap     <= '0;
      best_val <= '0;
      best_idx <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      digit_r  <= '0;
      conf_r   <= '0;
      valid_r  <= 1'b0;
    end else if (bus.clear) begin
      // Abort keeps the last published result intact.
      state  <= IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            snap   <= bus.digit_weights;
            state  <= SCAN;
            busy_r <= 1'b1;
          end
        end
        SCAN: begin
          best_val <= nxt_val;
          best_idx <= nxt_idx;
          if (last) begin
            state   <= DONE;
            done_r  <= 1'b1;
            digit_r <= nxt_idx;
            conf_r  <= nxt_val;
            valid_r <= (nxt_val >= THR);
          end
        end
        DONE: begin
          state  <= IDLE;
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.digit      = digit_r;
  assign bus.confidence = conf_r;
  assign bus.valid      = valid_r;
endmodule

// File: tb/tb_digit_decider.sv
// Directed bench for digit_decider: vector table plus handshake corner sequences.
module tb_digit_decider;
  import digit_recog_pkg::*;

  logic clk = 1'b0;
  logic n_rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  digit_decider_if bus ();
  digit_decider #(.THRESHOLD(8)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  typedef struct {
    act_arr_t   w;
    logic [3:0] d;
    logic [3:0] c;
    logic       v;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int d, input int c, input int v);
    chk({tag, ".digit"}, int'(bus.digit), d);
    chk({tag, ".conf"},  int'(bus.confidence), c);
    chk({tag, ".valid"}, int'(bus.valid), v);
  endtask

  // Launch a classification; lat is the cycle in which done is seen
  // (cycle 1 follows the start edge), busy_cnt counts busy cycles up to it.
  task automatic classify(input act_arr_t w, output int lat, output int busy_cnt);
    @(negedge clk);
    bus.digit_weights = w;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    busy_cnt = int'(bus.busy);
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
      busy_cnt += int'(bus.busy);
    end
    if (!bus.done) lat = -1;
  endtask

  int lat, bcnt, dcnt, d1, d2;

  initial begin
    vecs[0] = '{act_arr_t'(40'h123456E789), 4'd6, 4'd14, 1'b1};
    vecs[1] = '{act_arr_t'(40'h5350000005), 4'd0, 4'd5,  1'b0};
    vecs[2] = '{act_arr_t'(40'h0000000000), 4'd0, 4'd0,  1'b0};
    vecs[3] = '{act_arr_t'(40'hFFFFFFFFFF), 4'd0, 4'd15, 1'b1};
    vecs[4] = '{act_arr_t'(40'h7778777777), 4'd3, 4'd8,  1'b1};
    vecs[5] = '{act_arr_t'(40'h7777777777), 4'd0, 4'd7,  1'b0};
    vecs[6] = '{act_arr_t'(40'h8888888889), 4'd9, 4'd9,  1'b1};

    bus.start = 1'b0;
    bus.clear = 1'b0;
    bus.digit_weights = '0;
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.busy", int'(bus.busy), 0);
    chk("rst.done", int'(bus.done), 0);
    chk_out("rst", 0, 0, 0);
    n_rst = 1'b1;

    foreach (vecs[i]) begin
      classify(vecs[i].w, lat, bcnt);
      chk($sformatf("v%0d.latency", i), lat, 11);
      chk($sformatf("v%0d.busy_cycles", i), bcnt, 11);
      chk_out($sformatf("v%0d", i), vecs[i].d, vecs[i].c, vecs[i].v);
      @(negedge clk);
      chk($sformatf("v%0d.done_pulse", i), int'(bus.done), 0);
      chk($sformatf("v%0d.busy_after", i), int'(bus.busy), 0);
    end

    // Async reset mid-scan clears everything and suppresses done.
    @(negedge clk);
    bus.digit_weights = act_arr_t'(40'h123456E789);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("midrst.busy", int'(bus.busy), 0);
    chk("midrst.done", int'(bus.done), 0);
    chk_out("midrst", 0, 0, 0);
    @(negedge clk);
    n_rst = 1'b1;
    dcnt = 0;
    repeat (15) begin
      @(negedge clk);
      dcnt += int'(bus.done) + int'(bus.busy);
    end
    chk("midrst.quiet", dcnt, 0);
    classify(act_arr_t'(40'h123456E789), lat, bcnt);
    chk("postrst.latency", lat, 11);
    chk_out("postrst", 6, 14, 1);

    // Snapshot isolation: weights change during the second SCAN cycle.
    @(negedge clk);
    bus.digit_weights = act_arr_t'(40'h000000000F);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.digit_weights = act_arr_t'(40'hFFFFFFFFFF);
    lat = 2;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("snap.latency", lat, 11);
    chk_out("snap", 9, 15, 1);

    // start held for 30 cycles: done pulses in cycles 11 and 23 only.
    @(negedge clk);
    @(negedge clk);
    bus.digit_weights = act_arr_t'(40'h123456E789);
    bus.start = 1'b1;
    dcnt = 0; d1 = -1; d2 = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (bus.done) begin
        dcnt++;
        if (d1 < 0) d1 = c; else if (d2 < 0) d2 = c;
      end
    end
    bus.start = 1'b0;
    chk("hold.pulses", dcnt, 2);
    chk("hold.first", d1, 11);
    chk("hold.second", d2, 23);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    chk("hold.clr_busy", int'(bus.busy), 0);

    // clear beats start in IDLE.
    bus.start = 1'b1;
    bus.clear = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.clear = 1'b0;
    chk("clrprio.busy", int'(bus.busy), 0);

    // Establish a known result, then abort a scan at SCAN cycle 5.
    classify(act_arr_t'(40'h7778777777), lat, bcnt);
    chk_out("preclr", 3, 8, 1);
    @(negedge clk);
    bus.digit_weights = act_arr_t'(40'h000000000F);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    chk("abort.busy", int'(bus.busy), 0);
    dcnt = 0;
    repeat (15) begin
      @(negedge clk);
      dcnt += int'(bus.done);
    end
    chk("abort.no_done", dcnt, 0);
    chk_out("abort.hold", 3, 8, 1);
    classify(act_arr_t'(40'h000000000F), lat, bcnt);
    chk("postclr.latency", lat, 11);
    chk_out("postclr", 9, 15, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
